// File: rtl/fetch_pc_if.sv
// fetch_pc_if: hazard-unit/PC-select side to fetch PC stage bundle
interface fetch_pc_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             enable;
    logic [WIDTH-1:0] pc_next;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             exc_valid;
    logic             flush;
    logic [WIDTH-1:0] pc_out;
    logic             pc_valid;
    logic             pc_misaligned;
    logic             redirect_pending;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output enable, pc_next, redirect_valid, redirect_pc, exc_valid, flush,
        input  pc_out, pc_valid, pc_misaligned, redirect_pending, stall_count
    );

    modport slave (
        input  enable, pc_next, redirect_valid, redirect_pc, exc_valid, flush,
        output pc_out, pc_valid, pc_misaligned, redirect_pending, stall_count
    );
endinterface

// File: rtl/fetch_pc_stage.sv
// fetch_pc_stage: fetch PC register with stall, flush, prioritised redirect and pending buffer
module fetch_pc_stage #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h00400020,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h80000180,
    parameter int               CNT_W      = 16
) (
    input logic        clk,
    input logic        reset,
    fetch_pc_if.slave  bus
);
    logic [WIDTH-1:0] pend_pc;
    logic             pend_valid;
    logic             pend_exc;
    logic [WIDTH-1:0] pc_sel;

    assign bus.redirect_pending = pend_valid;

    // Source for the next fetch PC: exception, then live redirect, then buffered redirect, then sequential
    always_comb begin
        pc_sel = bus.exc_valid      ? EXC_VECTOR :
                 bus.redirect_valid ? bus.redirect_pc :
                 pend_valid         ? pend_pc :
                                      bus.pc_next;
    end

    // PC, bubble flag, pending redirect buffer and saturating stall counter
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.pc_out        <= RESET_PC;
            bus.pc_valid      <= 1'b1;
            bus.pc_misaligned <= |RESET_PC[1:0];
            bus.stall_count   <= '0;
            pend_pc           <= RESET_PC;
            pend_valid        <= 1'b0;
            pend_exc          <= 1'b0;
        end else begin
            if (bus.enable) begin
                bus.pc_out        <= pc_sel;
                bus.pc_misaligned <= |pc_sel[1:0];
                pend_valid        <= 1'b0;
                pend_exc          <= 1'b0;
            end else begin
                if (bus.exc_valid) begin
                    pend_pc    <= EXC_VECTOR;
                    pend_exc   <= 1'b1;
                    pend_valid <= 1'b1;
                end else if (bus.redirect_valid && !pend_exc) begin
                    pend_pc    <= bus.redirect_pc;
                    pend_valid <= 1'b1;
                end
                if (bus.stall_count != '1)
                    bus.stall_count <= bus.stall_count + 1'b1;
            end
            if (bus.flush)
                bus.pc_valid <= 1'b0;
            else if (bus.enable)
                bus.pc_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_pc_stage.sv
// tb_fetch_pc_stage: directed scoreboard bench for fetch_pc_stage
module tb_fetch_pc_stage;
    localparam logic [31:0] RPC = 32'h00400020;
    localparam logic [31:0] EXC = 32'h80000180;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        mis;
        logic        pend;
        logic [3:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;
    exp_t q[$];

    fetch_pc_if #(.WIDTH(32), .CNT_W(4)) bus ();

    fetch_pc_stage #(.WIDTH(32), .RESET_PC(RPC), .EXC_VECTOR(EXC), .CNT_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of stimulus; the expected post-edge state is queued for the monitor
    task automatic step(input logic rst, input logic en, input logic [31:0] pcn,
                        input logic rv, input logic [31:0] rpc, input logic ev, input logic fl,
                        input logic [31:0] e_pc, input logic e_valid, input logic e_mis,
                        input logic e_pend, input logic [3:0] e_cnt);
        exp_t e;
        @(negedge clk);
        reset = rst;
        bus.enable = en;
        bus.pc_next = pcn;
        bus.redirect_valid = rv;
        bus.redirect_pc = rpc;
        bus.exc_valid = ev;
        bus.flush = fl;
        @(posedge clk);
        e.pc = e_pc;
        e.valid = e_valid;
        e.mis = e_mis;
        e.pend = e_pend;
        e.cnt = e_cnt;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_out", bus.pc_out, e.pc);
                chk("pc_valid", 32'(bus.pc_valid), 32'(e.valid));
                chk("pc_misaligned", 32'(bus.pc_misaligned), 32'(e.mis));
                chk("redirect_pending", 32'(bus.redirect_pending), 32'(e.pend));
                chk("stall_count", 32'(bus.stall_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        bus.enable = 1'b0;
        bus.pc_next = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.exc_valid = 1'b0;
        bus.flush = 1'b0;
        // reset overrides a simultaneous exception
        step(1, 0, 0, 0, 0, 1, 0, RPC, 1, 0, 0, 0);
        step(0, 1, 32'h00400024, 0, 0, 0, 0, 32'h00400024, 1, 0, 0, 0);
        step(0, 1, 32'h00400028, 0, 0, 0, 0, 32'h00400028, 1, 0, 0, 0);
        step(0, 1, 32'h0040002C, 0, 0, 0, 0, 32'h0040002C, 1, 0, 0, 0);
        // exception beats redirect on the same edge
        step(0, 1, 32'h00400030, 1, 32'h00400100, 1, 0, EXC, 1, 0, 0, 0);
        // redirect during stall is buffered then released
        step(0, 0, 0, 1, 32'h00400200, 0, 0, EXC, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, EXC, 1, 0, 1, 2);
        step(0, 0, 0, 0, 0, 0, 0, EXC, 1, 0, 1, 3);
        step(0, 1, 32'h00400030, 0, 0, 0, 0, 32'h00400200, 1, 0, 0, 3);
        // pending exception is not overwritten by a later redirect
        step(0, 0, 0, 0, 0, 1, 0, 32'h00400200, 1, 0, 1, 4);
        step(0, 0, 0, 1, 32'h00400300, 0, 0, 32'h00400200, 1, 0, 1, 5);
        step(0, 1, 32'h00400204, 0, 0, 0, 0, EXC, 1, 0, 0, 5);
        // flush with enable: PC advances, bubble marked
        step(0, 1, 32'h00400040, 0, 0, 0, 1, 32'h00400040, 0, 0, 0, 5);
        step(0, 1, 32'h00400044, 0, 0, 0, 0, 32'h00400044, 1, 0, 0, 5);
        // misaligned redirect flagged on the same edge
        step(0, 1, 32'h00400048, 1, 32'h00400102, 0, 0, 32'h00400102, 1, 1, 0, 5);
        step(0, 1, 32'h00400104, 0, 0, 0, 0, 32'h00400104, 1, 0, 0, 5);
        // flush during stall clears valid, which then holds until enable
        step(0, 0, 0, 0, 0, 0, 1, 32'h00400104, 0, 0, 0, 6);
        step(0, 0, 0, 0, 0, 0, 0, 32'h00400104, 0, 0, 0, 7);
        step(0, 1, 32'h00400108, 0, 0, 0, 0, 32'h00400108, 1, 0, 0, 7);
        // newer redirect replaces older buffered redirect
        step(0, 0, 0, 1, 32'h00400500, 0, 0, 32'h00400108, 1, 0, 1, 8);
        step(0, 0, 0, 1, 32'h00400600, 0, 0, 32'h00400108, 1, 0, 1, 9);
        step(0, 1, 32'h0040010C, 0, 0, 0, 0, 32'h00400600, 1, 0, 0, 9);
        // exception replaces buffered redirect
        step(0, 0, 0, 1, 32'h00400700, 0, 0, 32'h00400600, 1, 0, 1, 10);
        step(0, 0, 0, 0, 0, 1, 0, 32'h00400600, 1, 0, 1, 11);
        step(0, 1, 32'h00400604, 0, 0, 0, 0, EXC, 1, 0, 0, 11);
        // long stall saturates the counter; redirect buffered midway
        for (int i = 0; i < 20; i++)
            step(0, 0, 0, i == 5, 32'h00400800, 0, 0, EXC, 1, 0, i >= 5,
                 (12 + i > 15) ? 4'd15 : 4'(12 + i));
        // reset mid-stall drops the pending redirect
        step(1, 0, 0, 1, 32'h00400900, 0, 0, RPC, 1, 0, 0, 0);
        step(0, 1, 32'h00400024, 0, 0, 0, 0, 32'h00400024, 1, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() != 0; i++)
            @(posedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
